// File: rtl/alu_4_pkg.sv
// Shared widths and the result record for the 4-bit SFQ ALU result collector.
// ALU_COLLECT_ZFLAG_EN adds a zero bit to each result record.
package alu_4_pkg;

  localparam int ALU_DATA_W  = 4;
  localparam int ALU_TAG_W   = 3;
  localparam int ALU_LATENCY = 7;

  typedef struct packed {
    logic [ALU_TAG_W-1:0]  tag;
    logic [ALU_DATA_W-1:0] data;
    logic                  carry;
`ifdef ALU_COLLECT_ZFLAG_EN
    logic                  zero;
`endif
  } alu_result_t;

  localparam int ALU_RESULT_W = $bits(alu_result_t);

endpackage

// File: rtl/alu_4_valid_delay.sv
// Shadow {valid, tag} shift register that tracks operations through the ALU.
// It has a synchronous clear so a reset drops every in-flight operation.
module alu_4_valid_delay
  import alu_4_pkg::*;
#(
  parameter int TAG_W   = ALU_TAG_W,
  parameter int LATENCY = ALU_LATENCY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag
);

  logic [LATENCY-1:0]            vld_pipe;
  logic [LATENCY-1:0][TAG_W-1:0] tag_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe[0] <= in_valid;
      tag_pipe[0] <= in_tag;
      for (int i = 1; i < LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  // The last stage lines up with the cycle the ALU drives this operation's result.
  assign out_valid = vld_pipe[LATENCY-1];
  assign out_tag   = tag_pipe[LATENCY-1];

endmodule

// File: rtl/alu_4_result_collector.sv
// Collects pipelined ALU results into a credit-throttled FIFO with a ready/valid port.
// ALU_COLLECT_ZFLAG_EN stores a zero flag per entry and exposes res_zero.
module alu_4_result_collector
  import alu_4_pkg::*;
#(
  parameter int DATA_W     = ALU_DATA_W,
  parameter int TAG_W      = ALU_TAG_W,
  parameter int LATENCY    = ALU_LATENCY,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid,
  input  logic [TAG_W-1:0]          issue_tag,
  output logic                      issue_ready,
  input  logic [DATA_W-1:0]         alu_z,
  input  logic                      alu_carry,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [DATA_W-1:0]         res_data,
  output logic                      res_carry,
  output logic [TAG_W-1:0]          res_tag,
`ifdef ALU_COLLECT_ZFLAG_EN
  output logic                      res_zero,
`endif
  output logic [$clog2(FIFO_DEPTH):0] credits
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic              carry;
`ifdef ALU_COLLECT_ZFLAG_EN
    logic              zero;
`endif
  } entry_t;

  logic             accept, pop, push, full, wr_en, err_overflow;
  logic [TAG_W-1:0] dly_tag;
  logic [AW:0]      wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  entry_t           mem [FIFO_DEPTH];
  entry_t           push_entry, head_nxt, head;

  assign issue_ready = (credits != '0);
  assign accept      = issue_valid && issue_ready;
  assign pop         = res_valid && res_ready;

  alu_4_valid_delay #(
    .TAG_W  (TAG_W),
    .LATENCY(LATENCY)
  ) u_delay (
    .clk      (clk),
    .rst      (rst),
    .in_valid (accept),
    .in_tag   (issue_tag),
    .out_valid(push),
    .out_tag  (dly_tag)
  );

  always_comb begin
    push_entry       = '0;
    push_entry.tag   = dly_tag;
    push_entry.data  = alu_z;
    push_entry.carry = alu_carry;
`ifdef ALU_COLLECT_ZFLAG_EN
    push_entry.zero  = (alu_z == '0);
`endif
  end

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still safe then.
  assign wr_en = push && (!full || pop);

  assign wr_ptr_nxt = wr_ptr + (AW+1)'(wr_en);
  assign rd_ptr_nxt = rd_ptr + (AW+1)'(pop);

  // Head register is loaded with next cycle's head; a push into an emptying FIFO is
  // taken from the write data since storage is only updated at the same edge.
  always_comb begin
    head_nxt = '0;
    if (rd_ptr_nxt != wr_ptr_nxt) begin
      if (wr_en && (wr_ptr[AW-1:0] == rd_ptr_nxt[AW-1:0]))
        head_nxt = push_entry;
      else
        head_nxt = mem[rd_ptr_nxt[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      res_valid    <= 1'b0;
      head         <= '0;
      credits      <= CW'(FIFO_DEPTH);
      err_overflow <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      res_valid <= (rd_ptr_nxt != wr_ptr_nxt);
      head      <= head_nxt;
      case ({accept, pop})
        2'b10:   credits <= credits - CW'(1);
        2'b01:   credits <= credits + CW'(1);
        default: credits <= credits;
      endcase
      if (push && full && !pop) err_overflow <= 1'b1;
    end
  end

  assign res_data  = head.data;
  assign res_carry = head.carry;
  assign res_tag   = head.tag;
`ifdef ALU_COLLECT_ZFLAG_EN
  assign res_zero  = head.zero;
`endif

  // Credits bound entries plus in-flight ops, so this flag should never rise.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !err_overflow);

endmodule

// File: tb/tb_alu_4_result_collector.sv
// Bench for alu_4_result_collector: ALU delay model, queue-based scoreboard,
// a vector table of single ops and hand-written multi-cycle sequences.
module tb_alu_4_result_collector;
  import alu_4_pkg::*;

  localparam int DW    = ALU_DATA_W;
  localparam int TW    = ALU_TAG_W;
  localparam int LAT   = ALU_LATENCY;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          issue_valid = 1'b0;
  logic [TW-1:0] issue_tag = '0;
  logic          issue_ready;
  logic [DW-1:0] alu_z;
  logic          alu_carry;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [DW-1:0] res_data;
  logic          res_carry;
  logic [TW-1:0] res_tag;
`ifdef ALU_COLLECT_ZFLAG_EN
  logic          res_zero;
`endif
  logic [CW-1:0] credits;

  logic [DW-1:0] op_a = '0, op_b = '0;
  logic          garbage = 1'b0;
  logic          chk_en = 1'b0;
  int            total = 0, bad = 0;
  int            delivered = 0;
  int            cyc = 0;

  always #5 clk = ~clk;

  alu_4_result_collector #(
    .DATA_W(DW), .TAG_W(TW), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .issue_valid(issue_valid),
    .issue_tag  (issue_tag),
    .issue_ready(issue_ready),
    .alu_z      (alu_z),
    .alu_carry  (alu_carry),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_carry  (res_carry),
    .res_tag    (res_tag),
`ifdef ALU_COLLECT_ZFLAG_EN
    .res_zero   (res_zero),
`endif
    .credits    (credits)
  );

  // ALU stand-in: an adder whose result appears LAT cycles after its operands.
  logic [LAT:1][2*DW-1:0] hist = '0;
  logic [31:0]            gnoise = '0;
  int                     alu_sum;
  always @(posedge clk) begin
    hist   <= {hist[LAT-1:1], {op_a, op_b}};
    gnoise <= $urandom;
  end
  always_comb begin
    alu_sum   = int'(hist[LAT][2*DW-1:DW]) + int'(hist[LAT][DW-1:0]);
    alu_z     = garbage ? gnoise[DW-1:0] : DW'(alu_sum % (1 << DW));
    alu_carry = garbage ? gnoise[DW]     : (alu_sum >= (1 << DW));
  end

  function automatic alu_result_t mk(input logic [TW-1:0] tag, input logic [DW-1:0] a, input logic [DW-1:0] b);
    int          s;
    alu_result_t r;
    s       = int'(a) + int'(b);
    r       = '0;
    r.tag   = tag;
    r.data  = DW'(s % (1 << DW));
    r.carry = (s >= (1 << DW));
`ifdef ALU_COLLECT_ZFLAG_EN
    r.zero  = (s % (1 << DW)) == 0;
`endif
    return r;
  endfunction

  // Reference model: in-flight list with due cycles and a plain result queue.
  typedef struct { alu_result_t r; int due; } flight_t;
  flight_t     inflight[$];
  alu_result_t outq[$];

  function automatic int model_credits();
    return DEPTH - inflight.size() - outq.size();
  endfunction

  always @(posedge clk) begin : model
    bit          acc;
    flight_t     f;
    cyc++;
    if (rst) begin
      inflight.delete();
      outq.delete();
    end else begin
      acc = issue_valid && (model_credits() > 0);
      if (res_ready && outq.size() > 0) begin
        void'(outq.pop_front());
        delivered++;
      end
      while (inflight.size() > 0 && inflight[0].due == cyc) begin
        f = inflight.pop_front();
        outq.push_back(f.r);
      end
      if (acc) begin
        f.r   = mk(issue_tag, op_a, op_b);
        f.due = cyc + LAT;
        inflight.push_back(f);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("sb_credits", 32'(credits), 32'(model_credits()));
      check("sb_issue_ready", 32'(issue_ready), 32'(model_credits() != 0));
      check("sb_res_valid", 32'(res_valid), 32'(outq.size() > 0));
      if (outq.size() > 0) begin
        check("sb_data", 32'(res_data), 32'(outq[0].data));
        check("sb_carry", 32'(res_carry), 32'(outq[0].carry));
        check("sb_tag", 32'(res_tag), 32'(outq[0].tag));
`ifdef ALU_COLLECT_ZFLAG_EN
        check("sb_zero", 32'(res_zero), 32'(outq[0].zero));
`endif
      end
    end
  end

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] a, b, z;
    logic          c;
  } vec_t;
  vec_t vecs[7];

  initial begin
    int n, d0;
    vecs[0] = '{tag: 3'd5, a: 4'd3,  b: 4'd4, z: 4'd7,  c: 1'b0};
    vecs[1] = '{tag: 3'd2, a: 4'd15, b: 4'd1, z: 4'd0,  c: 1'b1};
    vecs[2] = '{tag: 3'd7, a: 4'd9,  b: 4'd9, z: 4'd2,  c: 1'b1};
    vecs[3] = '{tag: 3'd0, a: 4'd0,  b: 4'd0, z: 4'd0,  c: 1'b0};
    vecs[4] = '{tag: 3'd1, a: 4'd10, b: 4'd5, z: 4'd15, c: 1'b0};
    vecs[5] = '{tag: 3'd6, a: 4'd8,  b: 4'd8, z: 4'd0,  c: 1'b1};
    vecs[6] = '{tag: 3'd3, a: 4'd10, b: 4'd0, z: 4'hA,  c: 1'b0};

    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_res_data", 32'(res_data), 0);
    check("rst_res_carry", 32'(res_carry), 0);
    check("rst_res_tag", 32'(res_tag), 0);
`ifdef ALU_COLLECT_ZFLAG_EN
    check("rst_res_zero", 32'(res_zero), 0);
`endif
    check("rst_credits", 32'(credits), DEPTH);
    check("rst_issue_ready", 32'(issue_ready), 1);
    rst = 1'b0;
    @(negedge clk);

    // Single ops: latency, payload, and credit return after the pop.
    for (int i = 0; i < 7; i++) begin
      issue_valid = 1'b1; issue_tag = vecs[i].tag; op_a = vecs[i].a; op_b = vecs[i].b;
      @(negedge clk);
      issue_valid = 1'b0; op_a = '0; op_b = '0;
      check("vec_credit_taken", 32'(credits), DEPTH - 1);
      repeat (LAT - 1) @(negedge clk);
      check("vec_not_early", 32'(res_valid), 0);
      @(negedge clk);
      check("vec_valid", 32'(res_valid), 1);
      check("vec_data", 32'(res_data), 32'(vecs[i].z));
      check("vec_carry", 32'(res_carry), 32'(vecs[i].c));
      check("vec_tag", 32'(res_tag), 32'(vecs[i].tag));
`ifdef ALU_COLLECT_ZFLAG_EN
      check("vec_zero", 32'(res_zero), 32'(vecs[i].z == 0));
`endif
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check("vec_credit_back", 32'(credits), DEPTH);
      check("vec_popped", 32'(res_valid), 0);
    end

    // Backpressure: fill every credit, a ninth request must be ignored.
    issue_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      issue_tag = TW'(i); op_a = DW'(i); op_b = 4'd1;
      @(negedge clk);
    end
    check("bp_credits_zero", 32'(credits), 0);
    check("bp_issue_ready", 32'(issue_ready), 0);
    issue_tag = 3'd6; op_a = 4'd9; op_b = 4'd9;
    @(negedge clk);
    issue_valid = 1'b0;
    check("bp_ninth_ignored", 32'(credits), 0);
    repeat (LAT) @(negedge clk);
    check("bp_full_valid", 32'(res_valid), 1);
    check("bp_head_tag", 32'(res_tag), 0);
    check("bp_head_data", 32'(res_data), 1);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("bp_next_tag", 32'(res_tag), 1);
    check("pop_credit_next", 32'(issue_ready), 1);
    check("pop_credits_one", 32'(credits), 1);

    // Issue and pop together at one credit, then stream near-full.
    issue_valid = 1'b1; res_ready = 1'b1; issue_tag = 3'd4; op_a = 4'd2; op_b = 4'd3;
    @(negedge clk);
    check("issue_pop_same", 32'(credits), 1);
    for (int i = 0; i < 12; i++) begin
      issue_tag = TW'(i); op_a = DW'($urandom); op_b = DW'($urandom);
      @(negedge clk);
    end
    issue_valid = 1'b0;
    repeat (LAT + DEPTH + 2) @(negedge clk);
    check("drain_credits", 32'(credits), DEPTH);
    res_ready = 1'b0;

    // Reset with three operations in flight and noise on the ALU outputs.
    issue_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue_tag = TW'(i + 1); op_a = 4'd1; op_b = DW'(i);
      @(negedge clk);
    end
    issue_valid = 1'b0;
    @(negedge clk);
    garbage = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_flight_credits", 32'(credits), DEPTH);
    for (int i = 0; i < LAT; i++) begin
      check("rst_flight_no_valid", 32'(res_valid), 0);
      @(negedge clk);
    end
    garbage = 1'b0;

    // Streaming with random backpressure.
    n = 0; d0 = delivered;
    for (int c = 0; c < 400 && n < 20; c++) begin
      res_ready   = ($urandom_range(0, 1) == 1);
      issue_valid = ($urandom_range(0, 3) != 0);
      issue_tag   = TW'($urandom); op_a = DW'($urandom); op_b = DW'($urandom);
      if (issue_valid && model_credits() > 0) n++;
      @(negedge clk);
    end
    issue_valid = 1'b0;
    check("stream_issued", 32'(n), 20);
    res_ready = 1'b1;
    for (int c = 0; c < 100 && (inflight.size() + outq.size()) > 0; c++) @(negedge clk);
    check("stream_delivered", 32'(delivered - d0), 20);
    check("stream_drained", 32'(res_valid), 0);
    check("stream_credits", 32'(credits), DEPTH);
    check("overflow_flag", 32'(dut.err_overflow), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1);
  end

endmodule

// File: doc/alu_4_result_collector.md
# alu_4_result_collector

Downstream companion to the pipelined 4-bit SFQ ALU. It consumes the ALU's `Z[3:0]` and `Carry_out` outputs. The ALU has no valid, tag or reset, so this block runs a shadow valid/tag pipeline matched to the ALU latency. It captures each real result into a small FIFO and presents it on a ready/valid port. A credit counter throttles operand issue so the FIFO can never overflow.

## Interface
Parameters:
- `DATA_W`, 4: ALU result width.
- `TAG_W`, 3: issue tag width.
- `LATENCY`, 7: clocks from operands at the ALU inputs to `Z`/`Carry_out` valid; must be ≥1.
- `FIFO_DEPTH`, 8: result FIFO entries; must be a power of two and ≥2.

Ports:
- `clk`  in  1  the single clock.
- `rst`  in  1  reset, synchronous and active-high.
- `issue_valid`  in  1  operands are presented to the ALU this cycle.
- `issue_tag`  in  `TAG_W`  tag for the issued operation.
- `issue_ready`  out  1  a credit is available; an issue counts only when `issue_valid && issue_ready`.
- `alu_z`  in  `DATA_W`  ALU `Z` output.
- `alu_carry`  in  1  ALU `Carry_out` output.
- `res_valid`  out  1  FIFO head is valid.
- `res_ready`  in  1  consumer accepts the head.
- `res_data`  out  `DATA_W`  head result.
- `res_carry`  out  1  head carry.
- `res_tag`  out  `TAG_W`  head tag.
- `res_zero`  out  1  head result is zero; present only with the macro described under Configuration.
- `credits`  out  clog2(`FIFO_DEPTH`)+1  free credits.

## Operation
- Credit counter:
  - Resets to `FIFO_DEPTH`.
  - Decrements by 1 on an accepted issue.
  - Increments by 1 on a pop (`res_valid && res_ready`).
  - Unchanged when both happen in the same cycle.
  - `issue_ready = (credits != 0)`, driven combinationally from the register.
- Shadow pipeline:
  - `LATENCY`-stage shift register of {valid, tag}.
  - Stage 0 loads {accepted issue, `issue_tag`}.
  - When the last stage is valid, {tag, `alu_z`, `alu_carry`} is pushed into the FIFO in that cycle.
- FIFO:
  - `FIFO_DEPTH` entries, read and write pointers with an extra wrap bit.
  - Full when the pointers are equal except for the wrap bit; empty when fully equal.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full (pop frees a slot) or empty (no bypass, so `res_valid` rises next cycle).
- Invariant: entries plus in-flight operations plus credits always equal `FIFO_DEPTH`. A push while full is therefore unreachable; it is a sticky internal error, asserted in simulation.
- Reset (including mid-operation):
  - Clears the shadow pipeline, FIFO pointers and all outputs.
  - Restores credits to `FIFO_DEPTH`.
  - ALU outputs for in-flight operations are ignored, because their valid bits are cleared.
- Reset values:
  - `res_valid`=0, `res_data`=0, `res_carry`=0, `res_tag`=0, `res_zero`=0.
  - `credits`=`FIFO_DEPTH`, `issue_ready`=1.

## Timing
- Issue accepted in cycle t → ALU output sampled in cycle t+`LATENCY` → `res_valid` is high at the earliest in cycle t+`LATENCY`+1.
- Results come out in issue order; tags are carried through and not interpreted.
- Back-to-back issues sustain one result per clock when `res_ready`=1.
- A pop in cycle t makes the credit usable in cycle t+1.
- Head outputs are registered from FIFO storage and stay stable while `res_valid && !res_ready`.

## Configuration
- `ALU_COLLECT_ZFLAG_EN`:
  - Defined: each FIFO entry stores an extra bit, `(alu_z == 0)`, computed at push, and `res_zero` is a port.
  - Undefined: the bit and the port are absent and the FIFO width is `DATA_W`+1+`TAG_W`.

## Structure
- Package `alu_4_pkg`:
  - `ALU_DATA_W`=4, `ALU_TAG_W`=3, `ALU_LATENCY`=7.
  - Packed struct `alu_result_t` {tag, data, carry[, zero]}.
- Sub-module `alu_4_valid_delay` holds the parameterised {valid, tag} shift register with synchronous clear. FIFO and credit logic stay in the top module.

## Test plan
- Single op: issue tag 5 at cycle 10; bench ALU model drives `alu_z`=7, `alu_carry`=0 at cycle 17 → `res_valid` in cycle 18 with data 7, carry 0, tag 5; `credits` returns to 8 after the pop.
- Backpressure: `res_ready`=0 and 8 back-to-back issues → `issue_ready`=0 after the 8th and `credits`=0; a 9th `issue_valid` is ignored; FIFO holds 8 entries in tag order 0–7.
- Simultaneous issue and pop with `credits`=1 → `credits` stays 1; full FIFO with push and pop in the same cycle → no loss, order preserved.
- Reset mid-flight: 3 ops in flight, `rst` for 1 cycle → no `res_valid` during the following 7 cycles despite garbage on `alu_z`; `credits`=8.
- Zero flag (macro defined): `alu_z`=0, `alu_carry`=1 → `res_zero`=1, `res_carry`=1; `alu_z`=4'hA → `res_zero`=0.
- Streaming: 20 issues with `res_ready` toggling randomly → all 20 results delivered in order, no error flag.
